// File: rtl/arr_unload_n_m_pkg.sv
// Shared types and helpers for the snapshot-and-stream array unloader.
package arr_unload_n_m_pkg;

  typedef enum logic {IDLE, SEND} unload_state_t;

  // Index width, kept at least one bit so a single-word array still has a legal index.
  function automatic int calc_iw(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/arr_unload_n_m_if.sv
// Load and stream handshake bundle between the unloader and its producer/consumer.
interface arr_unload_n_m_if #(
  parameter int n = 4,
  parameter int m = 16
);
  import arr_unload_n_m_pkg::*;

  localparam int IW = calc_iw(m);

  logic [n-1:0]  In_i [m];
  logic          load_valid_i;
  logic          load_ready_o;
  logic [n-1:0]  Out_o;
  logic [IW-1:0] idx_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          last_o;
  logic          busy_o;

  modport slave (
    input  In_i, load_valid_i, out_ready_i,
    output load_ready_o, Out_o, idx_o, out_valid_o, last_o, busy_o
  );

  modport master (
    output In_i, load_valid_i, out_ready_i,
    input  load_ready_o, Out_o, idx_o, out_valid_o, last_o, busy_o
  );

endinterface

// File: rtl/arr_unload_n_m_cnt_idx_m.sv
// Word index counter: clears on a new snapshot, steps on each transfer, wraps to 0 after M-1.
module cnt_idx_m #(
  parameter int M  = 16,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] idx,
  output logic          term
);

  assign term = (idx == IW'(M - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= term ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/arr_unload_n_m.sv
// Captures a parallel snapshot of m words and streams it out, word 0 first, on valid/ready.
module arr_unload_n_m
  import arr_unload_n_m_pkg::*;
#(
  parameter int           n   = 4,
  parameter int           m   = 16,
  parameter logic [n-1:0] val = '1
) (
  input logic              clk_i,
  input logic              rst_i,
  arr_unload_n_m_if.slave  bus
);

  localparam int IW = calc_iw(m);

  unload_state_t state;
  unload_state_t state_next;
  logic [n-1:0]  shadow [m];
  logic [IW-1:0] idx;
  logic          term;
  logic          out_valid;
  logic          xfer;
  logic          load_ready;
  logic          load_fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A load accepted together with the final transfer keeps us in SEND with no idle bubble.
  always_comb begin
    state_next = state;
    out_valid  = (state == SEND);
    xfer       = out_valid & bus.out_ready_i;
    load_ready = (state == IDLE) | (xfer & term);
    load_fire  = bus.load_valid_i & load_ready;
    if (load_fire) begin
      state_next = SEND;
    end else if (xfer && term) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < m; i++) shadow[i] <= val;
    end else if (load_fire) begin
      for (int i = 0; i < m; i++) shadow[i] <= bus.In_i[i];
    end
  end

  cnt_idx_m #(
    .M  (m),
    .IW (IW)
  ) u_cnt (
    .clk  (clk_i),
    .rst  (rst_i),
    .clr  (load_fire),
    .en   (xfer),
    .idx  (idx),
    .term (term)
  );

  // idx sits at 0 whenever idle, so this read also yields shadow[0] in IDLE.
  assign bus.Out_o        = shadow[idx];
  assign bus.idx_o        = idx;
  assign bus.out_valid_o  = out_valid;
  assign bus.busy_o       = out_valid;
  assign bus.last_o       = out_valid & term;
  assign bus.load_ready_o = load_ready;

endmodule

// File: tb/tb_arr_unload_n_m.sv
// Directed bench for arr_unload_n_m: a vector table on an m=4 instance plus an m=1 sequence.
module tb_arr_unload_n_m;

  logic clk;
  logic rst;

  arr_unload_n_m_if #(.n(4), .m(4)) bus4 ();
  arr_unload_n_m_if #(.n(4), .m(1)) bus1 ();

  arr_unload_n_m #(.n(4), .m(4), .val(4'hF)) u4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4.slave)
  );

  arr_unload_n_m #(.n(4), .m(1), .val(4'hA)) u1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        lv;
    logic        ordy;
    logic [15:0] in_flat;
    logic        ev;
    logic [3:0]  eo;
    logic [1:0]  ei;
    logic        el;
    logic        eb;
    logic        elr;
  } vec_t;

  vec_t vecs [25];
  int   n_cmp;
  int   n_bad;

  function automatic vec_t mk(logic r, logic lv, logic ordy, logic [15:0] inf,
                              logic ev, logic [3:0] eo, logic [1:0] ei,
                              logic el, logic eb, logic elr);
    vec_t v;
    v.rst = r; v.lv = lv; v.ordy = ordy; v.in_flat = inf;
    v.ev = ev; v.eo = eo; v.ei = ei; v.el = el; v.eb = eb; v.elr = elr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    bus4.load_valid_i = v.lv;
    bus4.out_ready_i  = v.ordy;
    for (int i = 0; i < 4; i++) bus4.In_i[i] = v.in_flat[4*i +: 4];
  endtask

  task automatic checkOutput(input int k, input vec_t v);
    check($sformatf("v%0d out_valid", k), 32'(bus4.out_valid_o), 32'(v.ev));
    check($sformatf("v%0d Out", k), 32'(bus4.Out_o), 32'(v.eo));
    check($sformatf("v%0d idx", k), 32'(bus4.idx_o), 32'(v.ei));
    check($sformatf("v%0d last", k), 32'(bus4.last_o), 32'(v.el));
    check($sformatf("v%0d busy", k), 32'(bus4.busy_o), 32'(v.eb));
    check($sformatf("v%0d load_ready", k), 32'(bus4.load_ready_o), 32'(v.elr));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus4.load_valid_i = 1'b0;
    bus4.out_ready_i  = 1'b0;
    for (int i = 0; i < 4; i++) bus4.In_i[i] = 4'h0;
    bus1.load_valid_i = 1'b0;
    bus1.out_ready_i  = 1'b0;
    bus1.In_i[0]      = 4'h0;

    // Fields: rst lv ordy In(flat, word0 in low nibble) | valid Out idx last busy load_ready
    vecs[0]  = mk(0, 1, 1, 16'h4321, 0, 4'hF, 0, 0, 0, 1);
    vecs[1]  = mk(0, 0, 1, 16'h0000, 1, 4'h1, 0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 1, 16'h0000, 1, 4'h2, 1, 0, 1, 0);
    vecs[3]  = mk(0, 0, 1, 16'h0000, 1, 4'h3, 2, 0, 1, 0);
    vecs[4]  = mk(0, 0, 1, 16'h0000, 1, 4'h4, 3, 1, 1, 1);
    vecs[5]  = mk(0, 0, 1, 16'h0000, 0, 4'h1, 0, 0, 0, 1);
    vecs[6]  = mk(0, 1, 0, 16'h4321, 0, 4'h1, 0, 0, 0, 1);
    vecs[7]  = mk(0, 0, 1, 16'h0000, 1, 4'h1, 0, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0, 16'hFFFF, 1, 4'h2, 1, 0, 1, 0);
    vecs[9]  = mk(0, 0, 0, 16'hEEEE, 1, 4'h2, 1, 0, 1, 0);
    vecs[10] = mk(0, 0, 0, 16'hDDDD, 1, 4'h2, 1, 0, 1, 0);
    vecs[11] = mk(0, 0, 1, 16'hCCCC, 1, 4'h2, 1, 0, 1, 0);
    vecs[12] = mk(0, 0, 1, 16'hBBBB, 1, 4'h3, 2, 0, 1, 0);
    vecs[13] = mk(0, 0, 1, 16'hAAAA, 1, 4'h4, 3, 1, 1, 1);
    vecs[14] = mk(0, 0, 0, 16'h0000, 0, 4'h1, 0, 0, 0, 1);
    vecs[15] = mk(0, 1, 1, 16'h4321, 0, 4'h1, 0, 0, 0, 1);
    vecs[16] = mk(0, 0, 1, 16'h0000, 1, 4'h1, 0, 0, 1, 0);
    vecs[17] = mk(0, 0, 1, 16'h0000, 1, 4'h2, 1, 0, 1, 0);
    vecs[18] = mk(0, 0, 1, 16'h0000, 1, 4'h3, 2, 0, 1, 0);
    vecs[19] = mk(0, 1, 1, 16'h6789, 1, 4'h4, 3, 1, 1, 1);
    vecs[20] = mk(0, 0, 1, 16'h0000, 1, 4'h9, 0, 0, 1, 0);
    vecs[21] = mk(0, 0, 1, 16'h0000, 1, 4'h8, 1, 0, 1, 0);
    vecs[22] = mk(1, 0, 1, 16'h0000, 1, 4'h7, 2, 0, 1, 0);
    vecs[23] = mk(0, 0, 1, 16'h0000, 0, 4'hF, 0, 0, 0, 1);
    vecs[24] = mk(0, 0, 1, 16'h0000, 0, 4'hF, 0, 0, 0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset load_ready", 32'(bus4.load_ready_o), 32'h1);
    check("reset out_valid", 32'(bus4.out_valid_o), 32'h0);
    check("reset busy", 32'(bus4.busy_o), 32'h0);
    check("reset last", 32'(bus4.last_o), 32'h0);
    check("reset Out", 32'(bus4.Out_o), 32'hF);
    check("reset idx", 32'(bus4.idx_o), 32'h0);

    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      applyStimulus(vecs[k]);
      #1;
      checkOutput(k, vecs[k]);
    end

    // Single-word array: one accepted transfer completes the snapshot.
    @(negedge clk);
    bus1.In_i[0] = 4'h5;
    bus1.load_valid_i = 1'b1;
    bus1.out_ready_i  = 1'b1;
    #1;
    check("m1 idle Out", 32'(bus1.Out_o), 32'hA);
    check("m1 idle valid", 32'(bus1.out_valid_o), 32'h0);
    check("m1 idle last", 32'(bus1.last_o), 32'h0);
    check("m1 idle load_ready", 32'(bus1.load_ready_o), 32'h1);
    @(negedge clk);
    bus1.load_valid_i = 1'b0;
    bus1.In_i[0] = 4'h0;
    #1;
    check("m1 send valid", 32'(bus1.out_valid_o), 32'h1);
    check("m1 send last", 32'(bus1.last_o), 32'h1);
    check("m1 send Out", 32'(bus1.Out_o), 32'h5);
    check("m1 send idx", 32'(bus1.idx_o), 32'h0);
    check("m1 send busy", 32'(bus1.busy_o), 32'h1);
    check("m1 send load_ready", 32'(bus1.load_ready_o), 32'h1);
    @(negedge clk);
    #1;
    check("m1 done valid", 32'(bus1.out_valid_o), 32'h0);
    check("m1 done busy", 32'(bus1.busy_o), 32'h0);
    check("m1 done Out", 32'(bus1.Out_o), 32'h5);

    // Single-word array stalled: the word and last flag hold until accepted.
    @(negedge clk);
    bus1.In_i[0] = 4'h3;
    bus1.load_valid_i = 1'b1;
    bus1.out_ready_i  = 1'b0;
    @(negedge clk);
    bus1.load_valid_i = 1'b0;
    bus1.In_i[0] = 4'h6;
    #1;
    check("m1 stall valid", 32'(bus1.out_valid_o), 32'h1);
    check("m1 stall Out", 32'(bus1.Out_o), 32'h3);
    check("m1 stall last", 32'(bus1.last_o), 32'h1);
    check("m1 stall load_ready", 32'(bus1.load_ready_o), 32'h0);
    @(negedge clk);
    bus1.out_ready_i = 1'b1;
    #1;
    check("m1 release valid", 32'(bus1.out_valid_o), 32'h1);
    check("m1 release Out", 32'(bus1.Out_o), 32'h3);
    check("m1 release load_ready", 32'(bus1.load_ready_o), 32'h1);
    @(negedge clk);
    #1;
    check("m1 after valid", 32'(bus1.out_valid_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
